// File: rtl/test_code_pkg.sv
// Shared widths, types and the constant table formula for the fetch-path test block.
package test_code_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;
    localparam int AW      = 5;
    localparam int DW      = 5;
    localparam int DEPTH   = 1 << AW;

    typedef logic [XLEN-1:0] pc_t;
    typedef logic [AW-1:0]   addr_t;
    typedef logic [DW-1:0]   word_t;

    // Table entry i holds (7*i + 3) mod 32; evaluated at elaboration time only.
    function automatic word_t rom_value(input int unsigned i);
        int unsigned v;
        v = (7 * i + 3) % 32;
        return word_t'(v);
    endfunction

endpackage

// File: rtl/test_code_rom.sv
// Constant 32x5 lookup table, read combinationally by word address.
module test_code_rom
    import test_code_pkg::*;
(
    input  addr_t addr,
    output word_t data
);

    word_t rom_table [DEPTH];

    // NOTE: the table is pure constant logic, so it has no clock and needs no reset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom_table[i] = rom_value(i);
    end

    // Combinational read: the registered copy of this value lives in the top.
    assign data = rom_table[addr];

endmodule

// File: rtl/test_code.sv
// Fetch-path bring-up block: word-stepping PC, address slice and registered table read.
module test_code
    import test_code_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] result
);

    pc_t   PC;
    word_t rom_data;

    // Word address is the PC with the byte offset dropped; wraps every 32 words.
    assign addr = PC[AW+1:2];

    test_code_rom u_rom (
        .addr (addr),
        .data (rom_data)
    );

    // PC advances one word per sampled inc; the add wraps silently at 2**XLEN.
    // NOTE: reset is in the sensitivity list so clearing happens without a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC <= '0;
        end else if (inc) begin
            // NOTE: non-blocking so every register samples pre-edge values of its peers.
            PC <= PC + pc_t'(PC_STEP);
        end
    end

    // Result captures the table entry addressed by the PC from before this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
        end else begin
            result <= rom_data;
        end
    end

endmodule

// File: tb/tb_test_code.sv
// Scoreboard bench for test_code: expectations are queued when stimulus is driven
// and popped when the clock edge that produces them has passed.
module tb_test_code;
    import test_code_pkg::*;

    typedef struct {
        pc_t   pc;
        word_t result;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          inc;
    logic [AW-1:0] addr;
    logic [DW-1:0] result;

    exp_t sb[$];
    pc_t  model_pc;
    int   n_compared;
    int   n_mismatched;

    test_code dut (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc),
        .addr   (addr),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference table straight from the formula (7*i+3) mod 32.
    function automatic word_t ref_rom(input int i);
        return word_t'((7 * i + 3) % 32);
    endfunction

    task automatic cmp_pc(input string name, input pc_t got, input pc_t want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: PC got %h want %h", name, got, want);
        end
    endtask

    task automatic cmp_w(input string name, input logic [4:0] got, input logic [4:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("FAIL %s: got %0d (%b) want %0d (%b)", name, got, got, want, want);
        end
    endtask

    // Drive one cycle from the negedge region, queue the expectation, check after the edge.
    task automatic step(input logic inc_v, input string tag);
        exp_t e;
        exp_t got;
        inc = inc_v;
        if (!reset) begin
            model_pc = '0;
            e.pc     = '0;
            e.result = '0;
        end else begin
            e.result = ref_rom(int'(model_pc[6:2]));
            if (inc_v) model_pc = model_pc + 32'd4;
            e.pc = model_pc;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: scoreboard empty at pop", tag);
        end else begin
            got = sb.pop_front();
            cmp_pc({tag, ".pc"}, dut.PC, got.pc);
            cmp_w({tag, ".addr"}, addr, got.pc[6:2]);
            cmp_w({tag, ".result"}, result, got.result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        inc   = 1'bx;
        #1;
        cmp_pc("reset_async.pc", dut.PC, '0);
        cmp_w("reset_async.result", result, 5'd0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) step(1'bx, "reset_hold");
    endtask

    task automatic test_release();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, "release_idle");
        cmp_w("release_first_result", result, 5'd3);
    endtask

    task automatic test_single_inc();
        step(1'b1, "single_inc");
        cmp_w("single_inc_addr1", addr, 5'd1);
        cmp_w("single_inc_result_old", result, 5'd3);
        step(1'b0, "single_inc_next");
        cmp_w("single_inc_result10", result, 5'd10);
    endtask

    task automatic test_sweep();
        logic [4:0] prev_addr;
        // Return to PC=0 through a short reset pulse taken at the negedge.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        model_pc = '0;
        for (int i = 0; i < 32; i++) begin
            prev_addr = addr;
            step(1'b1, "sweep");
            if (prev_addr == 5'd31) cmp_w("sweep_rom31", result, 5'd28);
        end
        cmp_pc("sweep_end_pc", dut.PC, 32'd128);
        cmp_w("sweep_end_addr", addr, 5'd0);
    endtask

    task automatic test_wrap();
        force dut.PC = 32'hFFFF_FFFC;
        #1;
        release dut.PC;
        #1;
        model_pc = 32'hFFFF_FFFC;
        cmp_pc("wrap_preload", dut.PC, 32'hFFFF_FFFC);
        step(1'b1, "wrap_inc");
        cmp_pc("wrap_zero", dut.PC, 32'd0);
        step(1'b0, "wrap_next");
        cmp_w("wrap_result3", result, 5'd3);
    endtask

    task automatic test_async_midcycle();
        step(1'b1, "pre_async");
        step(1'b1, "pre_async");
        inc = 1'b1;
        #2;
        cmp_pc("async_pc8", dut.PC, 32'd8);
        reset = 1'b0;
        #1;
        cmp_pc("async_clear.pc", dut.PC, '0);
        cmp_w("async_clear.addr", addr, 5'd0);
        cmp_w("async_clear.result", result, 5'd0);
        @(negedge clk);
        step(1'b1, "async_hold");
        step(1'b1, "async_hold");
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_pc     = '0;
        test_reset();
        test_release();
        test_single_inc();
        test_sweep();
        test_wrap();
        test_async_midcycle();
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    // Watchdog so a stalled run still ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
